passthrough_queue: RTL and testbench



---
 rtl/passthrough_queue_pkg.sv | 23 ++
 rtl/passthrough_queue_if.sv | 35 +++
 rtl/passthrough_queue_ptr.sv | 42 ++++
 rtl/passthrough_queue.sv | 103 ++++++++++
 tb/tb_passthrough_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/passthrough_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : passthrough_pkg
//  Purpose  : Shared default sizes and width helpers for passthrough_queue.
//  Revision : 1.0  initial release
// ============================================================================
package passthrough_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/passthrough_queue_if.sv
`default_nettype none
// ============================================================================
//  Interface : passthrough_queue_if
//  Purpose   : Enqueue/dequeue ready-valid bundle plus occupancy count.
//  Revision  : 1.0  initial release
// ============================================================================
interface passthrough_queue_if
    import passthrough_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    logic                      io_enq_valid;
    logic                      io_enq_ready;
    logic [WIDTH-1:0]          io_enq_bits;
    logic                      io_deq_valid;
    logic                      io_deq_ready;
    logic [WIDTH-1:0]          io_deq_bits;
    logic [cnt_w(DEPTH)-1:0]   io_count;

    // Queue side
    modport slave (
        input  io_enq_valid, io_enq_bits, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count
    );

    // Producer/consumer side
    modport master (
        output io_enq_valid, io_enq_bits, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count
    );

endinterface
`default_nettype wire

// File: rtl/passthrough_queue_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : queue_ptr
//  Purpose  : Modulo-DEPTH wrapping pointer with increment enable.
//  Revision : 1.0  initial release
// ============================================================================
module queue_ptr
    import passthrough_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inc_i,
    output logic [ptr_w(DEPTH)-1:0]   ptr_o
);

    localparam int            PW     = ptr_w(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/passthrough_queue.sv
`default_nettype none
// ============================================================================
//  Module   : passthrough_queue
//  Purpose  : DEPTH-entry ready/valid FIFO; PASSTHROUGH_QUEUE_FLOW_EN adds
//             combinational enq->deq passthrough when empty.
//  Revision : 1.0  initial release
// ============================================================================
module passthrough_queue
    import passthrough_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    passthrough_queue_if.slave q
);

    localparam int            PW     = ptr_w(DEPTH);
    localparam int            CW     = cnt_w(DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    w_wptr;
    logic [PW-1:0]    w_rptr;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic w_empty;
    logic w_full;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty = (cnt_q == '0);
    assign w_full  = (cnt_q == C_FULL);

    // Ready depends on stored state only: a full queue never accepts, even on a same-cycle pop.
    assign q.io_enq_ready = ~w_full;
    assign q.io_count     = cnt_q;

`ifdef PASSTHROUGH_QUEUE_FLOW_EN
    assign w_bypass       = w_empty & q.io_enq_valid & q.io_deq_ready;
    assign q.io_deq_valid = ~w_empty | q.io_enq_valid;
    assign q.io_deq_bits  = w_empty ? q.io_enq_bits : mem_q[w_rptr];
`else
    assign w_bypass       = 1'b0;
    assign q.io_deq_valid = ~w_empty;
    assign q.io_deq_bits  = mem_q[w_rptr];
`endif

    assign w_enq_fire = q.io_enq_valid & q.io_enq_ready;
    assign w_deq_fire = q.io_deq_valid & q.io_deq_ready;

    // A bypassed byte leaves in the same cycle, so storage and pointers stay put.
    assign w_push = w_enq_fire & ~w_bypass;
    assign w_pop  = w_deq_fire & ~w_bypass;

    always_comb begin
        cnt_d = cnt_q;
        if (w_push & ~w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (w_pop & ~w_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[w_wptr] <= q.io_enq_bits;
        end
    end

    queue_ptr #(
        .DEPTH (DEPTH)
    ) u_wptr (
        .clock (clock),
        .reset (reset),
        .inc_i (w_push),
        .ptr_o (w_wptr)
    );

    queue_ptr #(
        .DEPTH (DEPTH)
    ) u_rptr (
        .clock (clock),
        .reset (reset),
        .inc_i (w_pop),
        .ptr_o (w_rptr)
    );

endmodule
`default_nettype wire

// File: tb/tb_passthrough_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_passthrough_queue
//  Purpose  : Self-checking bench: DEPTH=4 directed table/sequences,
//             DEPTH=3 random traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_passthrough_queue;

`ifdef PASSTHROUGH_QUEUE_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic clock;
    logic reset;

    passthrough_queue_if #(.WIDTH(8), .DEPTH(4)) q4 ();
    passthrough_queue_if #(.WIDTH(8), .DEPTH(3)) q3 ();

    passthrough_queue #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .q     (q4)
    );

    passthrough_queue #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .q     (q3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       ev;
        logic [7:0] eb;
        logic       dr;
        logic       er;
        logic       dv;
        logic [7:0] db;
        logic       chk;
        logic [2:0] cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    function automatic vec_t mk(logic ev, logic [7:0] eb, logic dr, logic er,
                                logic dv, logic [7:0] db, logic chk, logic [2:0] cnt);
        vec_t v;
        v.ev = ev; v.eb = eb; v.dr = dr; v.er = er;
        v.dv = dv; v.db = db; v.chk = chk; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a4(input logic ev, input logic [7:0] eb, input logic dr);
        q4.io_enq_valid = ev;
        q4.io_enq_bits  = eb;
        q4.io_deq_ready = dr;
    endtask

    task automatic a3(input logic ev, input logic [7:0] eb, input logic dr);
        q3.io_enq_valid = ev;
        q3.io_enq_bits  = eb;
        q3.io_deq_ready = dr;
    endtask

    logic [7:0] mq [$];

    initial begin
        // Rows give inputs and the outputs expected before the edge that follows.
        tbl[0]  = mk(1, 8'hA5, 0, 1, FLOW, 8'hA5, FLOW, 3'd0);
        tbl[1]  = mk(0, 8'h00, 0, 1, 1,    8'hA5, 1,    3'd1);
        tbl[2]  = mk(0, 8'h00, 1, 1, 1,    8'hA5, 1,    3'd1);
        tbl[3]  = mk(0, 8'h00, 0, 1, 0,    8'h00, 0,    3'd0);
        tbl[4]  = mk(1, 8'h01, 0, 1, FLOW, 8'h01, FLOW, 3'd0);
        tbl[5]  = mk(1, 8'h02, 0, 1, 1,    8'h01, 1,    3'd1);
        tbl[6]  = mk(1, 8'h03, 0, 1, 1,    8'h01, 1,    3'd2);
        tbl[7]  = mk(1, 8'h04, 0, 1, 1,    8'h01, 1,    3'd3);
        tbl[8]  = mk(1, 8'h05, 0, 0, 1,    8'h01, 1,    3'd4);
        tbl[9]  = mk(1, 8'h05, 0, 0, 1,    8'h01, 1,    3'd4);
        tbl[10] = mk(1, 8'h05, 1, 0, 1,    8'h01, 1,    3'd4);
        tbl[11] = mk(1, 8'h05, 1, 1, 1,    8'h02, 1,    3'd3);
        tbl[12] = mk(0, 8'h00, 1, 1, 1,    8'h03, 1,    3'd3);
        tbl[13] = mk(0, 8'h00, 1, 1, 1,    8'h04, 1,    3'd2);
        tbl[14] = mk(0, 8'h00, 1, 1, 1,    8'h05, 1,    3'd1);
        tbl[15] = mk(0, 8'h00, 0, 1, 0,    8'h00, 0,    3'd0);

        reset = 1'b0;
        a4(0, 8'h00, 0);
        a3(0, 8'h00, 0);
        repeat (3) step();
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_enq_ready", 32'(q4.io_enq_ready), 32'd1);
            check("idle_deq_valid", 32'(q4.io_deq_valid), 32'd0);
            check("idle_count",     32'(q4.io_count),     32'd0);
            step();
        end

        for (int i = 0; i < NV; i++) begin
            a4(tbl[i].ev, tbl[i].eb, tbl[i].dr);
            #1;
            check($sformatf("tbl%0d_enq_ready", i), 32'(q4.io_enq_ready), 32'(tbl[i].er));
            check($sformatf("tbl%0d_deq_valid", i), 32'(q4.io_deq_valid), 32'(tbl[i].dv));
            check($sformatf("tbl%0d_count", i),     32'(q4.io_count),     32'(tbl[i].cnt));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_deq_bits", i), 32'(q4.io_deq_bits), 32'(tbl[i].db));
            end
            step();
        end

        // Hold two entries, then push and pop together across the pointer wrap.
        a4(1, 8'hE0, 0); step();
        a4(1, 8'hE1, 0); step();
        #1;
        check("sim_pre_count", 32'(q4.io_count), 32'd2);
        for (int i = 0; i < 6; i++) begin
            a4(1, 8'(8'h10 + i), 1);
            #1;
            check($sformatf("sim%0d_deq_bits", i), 32'(q4.io_deq_bits),
                  (i < 2) ? 32'(8'hE0 + i) : 32'(8'h10 + i - 2));
            check($sformatf("sim%0d_enq_ready", i), 32'(q4.io_enq_ready), 32'd1);
            step();
            check($sformatf("sim%0d_count", i), 32'(q4.io_count), 32'd2);
        end
        a4(0, 8'h00, 1);
        step();
        check("sim_drain_bits", 32'(q4.io_deq_bits), 32'h15);
        step();
        a4(0, 8'h00, 0);
        #1;
        check("sim_drain_count", 32'(q4.io_count), 32'd0);

        // Asynchronous reset with three entries stored.
        for (int i = 0; i < 3; i++) begin
            a4(1, 8'(8'h70 + i), 0);
            step();
        end
        a4(0, 8'h00, 0);
        #1;
        check("rst_pre_count", 32'(q4.io_count), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_enq_ready", 32'(q4.io_enq_ready), 32'd1);
        check("rst_async_deq_valid", 32'(q4.io_deq_valid), 32'd0);
        check("rst_async_count",     32'(q4.io_count),     32'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_post_count",     32'(q4.io_count),     32'd0);
        check("rst_post_deq_valid", 32'(q4.io_deq_valid), 32'd0);

        // Empty queue, producer and consumer both active.
        a4(1, 8'h3C, 1);
        #1;
        check("lat_same_deq_valid", 32'(q4.io_deq_valid), 32'(FLOW));
        if (q4.io_deq_valid) begin
            check("lat_same_deq_bits", 32'(q4.io_deq_bits), 32'h3C);
        end
        step();
        a4(0, 8'h00, 0);
        #1;
        check("lat_next_count",     32'(q4.io_count),     FLOW ? 32'd0 : 32'd1);
        check("lat_next_deq_valid", 32'(q4.io_deq_valid), FLOW ? 32'd0 : 32'd1);
        if (q4.io_deq_valid) begin
            check("lat_next_deq_bits", 32'(q4.io_deq_bits), 32'h3C);
        end
        a4(0, 8'h00, 1);
        step();
        a4(0, 8'h00, 0);
        #1;
        check("lat_end_count", 32'(q4.io_count), 32'd0);

        // Random traffic on the three-entry queue against a list model.
        for (int c = 0; c < 2000; c++) begin
            logic       ev;
            logic       dr;
            logic [7:0] eb;
            logic       x_er;
            logic       x_dv;
            logic [7:0] x_db;
            logic       enq;
            logic       deq;
            ev = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            eb = 8'($urandom);
            a3(ev, eb, dr);
            #1;
            x_er = (mq.size() != 3);
            x_dv = (mq.size() != 0) || (FLOW && ev);
            x_db = (mq.size() != 0) ? mq[0] : eb;
            check("rnd_enq_ready", 32'(q3.io_enq_ready), 32'(x_er));
            check("rnd_deq_valid", 32'(q3.io_deq_valid), 32'(x_dv));
            check("rnd_count",     32'(q3.io_count),     32'(mq.size()));
            if (x_dv) begin
                check("rnd_deq_bits", 32'(q3.io_deq_bits), 32'(x_db));
            end
            enq = ev && x_er;
            deq = x_dv && dr;
            step();
            if (!(FLOW && mq.size() == 0 && enq && deq)) begin
                if (deq) void'(mq.pop_front());
                if (enq) mq.push_back(eb);
            end
        end
        a3(0, 8'h00, 0);
        #1;
        check("rnd_final_count", 32'(q3.io_count), 32'(mq.size()));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
